aes_round_pipe: RTL

//  Parametrised, elastic AES encryption round: SubBytes, ShiftRows, MixColumns, AddRoundKey.

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/aes_round_comb.sv | 28 ++
 rtl/aes_round_pipe.sv | 116 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and byte-level helpers for the round datapath.
// State layout: byte i of the 128-bit state sits at [127-8i -: 8], in column-major order.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of MixColumns; row 0 is the most significant byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic int byte_lsb(input int idx);
    return AES_STATE_W - 8 - 8 * idx;
  endfunction

  // Source byte index that ShiftRows moves into byte idx.
  function automatic int shift_rows_src(input int idx);
    int row, col;
    row = idx % 4;
    col = idx / 4;
    return row + 4 * ((col + row) % 4);
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// Stateless AES round arithmetic: ShiftRows(SubBytes(x)) and MixColumns(y) as
// two independent paths, so the top can place a register between them.
module aes_round_comb import aes_pkg::*; (
  input  logic [AES_STATE_W-1:0] sub_in,
  output logic [AES_STATE_W-1:0] shift_out,
  input  logic [AES_STATE_W-1:0] mix_in,
  output logic [AES_STATE_W-1:0] mix_out
);

  logic [AES_STATE_W-1:0] sub_bytes;

  always_comb begin
    // NOTE: defaults first so no path through the block can leave a bit unassigned and infer a latch.
    sub_bytes = '0;
    shift_out = '0;
    for (int i = 0; i < AES_BYTES; i++) begin
      sub_bytes[byte_lsb(i) +: 8] = sbox(sub_in[byte_lsb(i) +: 8]);
    end
    for (int i = 0; i < AES_BYTES; i++) begin
      shift_out[byte_lsb(i) +: 8] = sub_bytes[byte_lsb(shift_rows_src(i)) +: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign mix_out[AES_STATE_W-1-32*c -: 32] = mix_column(mix_in[AES_STATE_W-1-32*c -: 32]);
  end

endmodule

// File: rtl/aes_round_pipe.sv
// Elastic AES encryption round with optional mid-round register, sideband tag
// and a scan chain through every stage flop.
module aes_round_pipe import aes_pkg::*; #(
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scan_input,
  output logic                   scan_output,
  input  logic                   scan_ck_en,
  input  logic                   scan_enable,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_final,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic [AES_STATE_W-1:0] in_key,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic [TAG_W-1:0]       out_tag
);

  // Field order here is also the scan order within each stage (MSB first).
  typedef struct packed {
    logic                   v;
    logic                   fin;
    logic [TAG_W-1:0]       tag;
    logic [AES_STATE_W-1:0] key;
    logic [AES_STATE_W-1:0] sr;
  } stage_a_t;

  typedef struct packed {
    logic                   v;
    logic [TAG_W-1:0]       tag;
    logic [AES_STATE_W-1:0] st;
  } stage_b_t;

  localparam int A_W     = $bits(stage_a_t);
  localparam int B_W     = $bits(stage_b_t);
  localparam int CHAIN_W = B_W + ((PIPE_STAGES == 2) ? A_W : 0);

  if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_cfg
    $error("aes_round_pipe: PIPE_STAGES must be 1 or 2, got %0d", PIPE_STAGES);
  end

  stage_a_t               a_in, a_q, b_src;
  stage_b_t               b_q;
  logic [AES_STATE_W-1:0] sr_comb, mix_res, b_state;
  logic                   a_load, b_load;

  aes_round_comb u_comb (
    .sub_in    (in_state),
    .shift_out (sr_comb),
    .mix_in    (b_src.sr),
    .mix_out   (mix_res)
  );

  assign a_in    = {in_valid, in_final, in_tag, in_key, sr_comb};
  assign b_state = (b_src.fin ? b_src.sr : mix_res) ^ b_src.key;

  // Scan mode freezes the functional path, so both load enables drop with it.
  assign b_load = !scan_enable && (!b_q.v || out_ready);
  assign a_load = !scan_enable && (!a_q.v || b_load);

  assign in_ready    = (PIPE_STAGES == 2) ? a_load : b_load;
  assign out_valid   = b_q.v && !scan_enable;
  assign out_state   = b_q.st;
  assign out_tag     = b_q.tag;
  assign scan_output = b_q.v;

  if (PIPE_STAGES == 2) begin : g_two
    logic [CHAIN_W-1:0] chain;

    assign b_src = a_q;
    assign chain = {b_q, a_q};

    // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
      end else if (scan_enable) begin
        if (scan_ck_en) {b_q, a_q} <= {chain[CHAIN_W-2:0], scan_input};
      end else begin
        if (b_load) begin
          if (b_src.v) b_q <= {1'b1, b_src.tag, b_state};
          else         b_q.v <= 1'b0;
        end
        if (a_load) begin
          if (a_in.v) a_q <= a_in;
          else        a_q.v <= 1'b0;
        end
      end
    end
  end else begin : g_one
    logic [CHAIN_W-1:0] chain;

    assign a_q   = '0;
    assign b_src = a_in;
    assign chain = b_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        b_q <= '0;
      end else if (scan_enable) begin
        if (scan_ck_en) b_q <= {chain[CHAIN_W-2:0], scan_input};
      end else if (b_load) begin
        if (b_src.v) b_q <= {1'b1, b_src.tag, b_state};
        else         b_q.v <= 1'b0;
      end
    end
  end

endmodule
